// File: rtl/eight_bit_serial_sub_module.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, with a
// start/done handshake and borrow, signed-overflow and zero flags.
module eight_bit_serial_sub_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_s;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             br_s;
    logic             d_s;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_s;
    logic             finish_s;

    // One full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
        logic [1:0] r;
        r[0] = ai ^ bi ^ bri;
        r[1] = (~ai & bi) | (~(ai ^ bi) & bri);
        return r;
    endfunction

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Current bit slice, the result as it stands after this bit, and overflow.
    always_comb begin
        {br_s, d_s} = sub_bit(a_sh_r[0], b_sh_r[0], br_r);
        res_s       = {d_s, res_r[WIDTH-1:1]};
        ovf_s       = (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_s[WIDTH-1]);
        finish_s    = (state_r == RUN) && (state_s == DONE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shift registers, result accumulator, counter and borrow flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            br_r    <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                        br_r    <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    res_r  <= res_s;
                    br_r   <= br_s;
                    cnt_r  <= cnt_r + CW'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Status outputs follow the next state; result flags update only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            busy <= (state_s == RUN);
            done <= (state_s == DONE);
            if (finish_s) begin
                diff <= res_s;
                bout <= br_s;
                ovf  <= ovf_s;
                zero <= (res_s == '0);
            end
        end
    end

endmodule

// File: tb/tb_eight_bit_serial_sub_module.sv
// Self-checking bench for eight_bit_serial_sub_module: directed corner cases
// plus randomized operands compared against an arithmetic reference model.
module tb_eight_bit_serial_sub_module;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int checks_r;
    int errors_r;

    eight_bit_serial_sub_module #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] md, output logic mbo,
                         output logic mo, output logic mz);
        int sa;
        int sb;
        int sd;
        md  = ma - mb;
        mbo = (ma < mb);
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        sd  = sa - sb;
        mo  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        mz  = (md == '0);
    endtask

    task automatic check_result(input logic [W-1:0] oa, input logic [W-1:0] ob);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        logic         ez;
        model(oa, ob, ed, eb, eo, ez);
        check_eq("diff", diff, ed);
        check_eq("bout", bout, eb);
        check_eq("ovf",  ovf,  eo);
        check_eq("zero", zero, ez);
    endtask

    // Must be called in IDLE; returns in IDLE with start low.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit disturb);
        int           lat;
        int           busy_n;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        logic         ez;
        model(oa, ob, ed, eb, eo, ez);
        a     = oa;
        b     = ob;
        start = 1'b1;
        step();
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (disturb) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        start = 1'b0;
        check_eq("latency", lat, W);
        check_eq("busy_cycles", busy_n, W);
        check_eq("busy_at_done", busy, 1'b0);
        check_result(oa, ob);
        step();
        check_eq("done_single", done, 1'b0);
        check_eq("hold_diff", diff, ed);
        check_eq("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int           cyc;
        int           last_done;
        int           ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks_r = 0;
        errors_r = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_diff", diff, 0);
        check_eq("rst_flags", {bout, ovf, zero}, 3'b000);
        rst = 1'b0;
        step();

        run_op(8'd100, 8'd37, 1'b0);
        run_op(8'd5, 8'd10, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h55, 8'h55, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'd12, 8'd200, 1'b1);

        // start held high: consecutive ops with no gap beyond the mandatory IDLE.
        a         = 8'd77;
        b         = 8'd150;
        start     = 1'b1;
        cyc       = 0;
        last_done = -1;
        ndone     = 0;
        while (ndone < 3 && cyc < 60) begin
            step();
            cyc++;
            if (done) begin
                ndone++;
                check_result(8'd77, 8'd150);
                if (last_done >= 0) begin
                    check_eq("b2b_gap_ok",
                             32'((cyc - last_done >= W + 1) && (cyc - last_done <= W + 2)), 1);
                end
                last_done = cyc;
            end
        end
        start = 1'b0;
        check_eq("b2b_count", ndone, 3);
        step();

        // Reset in the middle of an op.
        a     = 8'd17;
        b     = 8'd99;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("mid_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_diff", diff, 0);
        check_eq("abort_flags", {done, bout, ovf, zero}, 4'b0000);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);
        run_op(8'd200, 8'd55, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
